mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 47 ++++
 rtl/mem_arbiter.sv | 99 +++++++++
 tb/tb_mem_arbiter.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - client and memory-side signal bundle for mem_arbiter
interface mem_arbiter_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
);
  logic              p0_req;
  logic              p0_we;
  logic [ADDR_W-1:0] p0_addr;
  logic [DATA_W-1:0] p0_wdata;
  logic              p0_gnt;
  logic              p0_rvalid;
  logic [DATA_W-1:0] p0_rdata;

  logic              p1_req;
  logic              p1_we;
  logic [ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0] p1_wdata;
  logic              p1_gnt;
  logic              p1_rvalid;
  logic [DATA_W-1:0] p1_rdata;

  logic              mem_wr;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Arbiter view
  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    output p0_gnt, p0_rvalid, p0_rdata,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    output p1_gnt, p1_rvalid, p1_rdata,
    output mem_wr, mem_rd, mem_addr, mem_wdata,
    input  mem_rdata
  );

  // Requesters plus data memory view
  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata,
    input  p0_gnt, p0_rvalid, p0_rdata,
    output p1_req, p1_we, p1_addr, p1_wdata,
    input  p1_gnt, p1_rvalid, p1_rdata,
    input  mem_wr, mem_rd, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port single-memory arbiter; MEM_ARB_ROUND_ROBIN_EN selects round-robin over fixed priority
module mem_arbiter #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input logic         clk,
  input logic         res,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t            state_q, state_d;
  logic              sel;       // port chosen in IDLE this cycle (0/1)
  logic              win_q;     // port owning the current transaction
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] p0_rdata_q;
  logic [DATA_W-1:0] p1_rdata_q;
  logic              any_req;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic              prio_q;    // port that wins a tie: the one not granted last
`endif

  assign any_req = bus.p0_req | bus.p1_req;

  // Winner selection: single requester always wins, ties resolved by priority
  always_comb begin
    sel = 1'b0;
    if (bus.p0_req && bus.p1_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      sel = prio_q;
`else
      sel = 1'b0;
`endif
    end else begin
      sel = bus.p1_req;
    end
  end

  // Next-state logic; requests are only looked at while IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = ISSUE;
      ISSUE:   state_d = we_q ? IDLE : RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from registered state so reset clears them at once
  always_comb begin
    bus.p0_gnt    = (state_q == ISSUE) && !win_q;
    bus.p1_gnt    = (state_q == ISSUE) &&  win_q;
    bus.mem_wr    = (state_q == ISSUE) &&  we_q;
    bus.mem_rd    = (state_q == ISSUE) && !we_q;
    bus.mem_addr  = addr_q;
    bus.mem_wdata = wdata_q;
    bus.p0_rvalid = (state_q == RESP) && !win_q;
    bus.p1_rvalid = (state_q == RESP) &&  win_q;
    bus.p0_rdata  = bus.p0_rvalid ? bus.mem_rdata : p0_rdata_q;
    bus.p1_rdata  = bus.p1_rvalid ? bus.mem_rdata : p1_rdata_q;
  end

  // State register, transaction latch and held read data
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q    <= IDLE;
      win_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      p0_rdata_q <= '0;
      p1_rdata_q <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      prio_q     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && any_req) begin
        win_q   <= sel;
        we_q    <= sel ? bus.p1_we    : bus.p0_we;
        addr_q  <= sel ? bus.p1_addr  : bus.p0_addr;
        wdata_q <= sel ? bus.p1_wdata : bus.p0_wdata;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        prio_q  <= ~sel;
`endif
      end
      if (state_q == RESP) begin
        if (win_q) p1_rdata_q <= bus.mem_rdata;
        else       p0_rdata_q <= bus.mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed and randomized self-checking bench for mem_arbiter
module tb_mem_arbiter;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic res;
  int   checks   = 0;
  int   failures = 0;

  mem_arbiter_if #(.ADDR_W(6), .DATA_W(32)) bus ();

  mem_arbiter #(.ADDR_W(6), .DATA_W(32)) dut (
    .clk (clk),
    .res (res),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Data memory with registered read port
  logic [31:0] mem_arr [64];
  always @(posedge clk) begin
    if (bus.mem_wr) mem_arr[bus.mem_addr] <= bus.mem_wdata;
    if (bus.mem_rd) bus.mem_rdata <= mem_arr[bus.mem_addr];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int p, input logic req, input logic we,
                       input logic [5:0] addr, input logic [31:0] wdata);
    if (p == 0) begin
      bus.p0_req = req; bus.p0_we = we; bus.p0_addr = addr; bus.p0_wdata = wdata;
    end else begin
      bus.p1_req = req; bus.p1_we = we; bus.p1_addr = addr; bus.p1_wdata = wdata;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_p0_gnt"},    bus.p0_gnt,    0);
    chk({tag, "_p1_gnt"},    bus.p1_gnt,    0);
    chk({tag, "_p0_rvalid"}, bus.p0_rvalid, 0);
    chk({tag, "_p1_rvalid"}, bus.p1_rvalid, 0);
    chk({tag, "_mem_wr"},    bus.mem_wr,    0);
    chk({tag, "_mem_rd"},    bus.mem_rd,    0);
    chk({tag, "_mem_addr"},  bus.mem_addr,  0);
    chk({tag, "_mem_wdata"}, bus.mem_wdata, 0);
    chk({tag, "_p0_rdata"},  bus.p0_rdata,  0);
    chk({tag, "_p1_rdata"},  bus.p1_rdata,  0);
  endtask

  // Random-phase model state
  logic        r_req   [2];
  logic        r_we    [2];
  logic [5:0]  r_addr  [2];
  logic [31:0] r_wdata [2];
  int          r_age   [2];
  logic        snap    [2];
  logic [31:0] shadow  [64];
  logic        shadow_ok [64];

  initial begin
    int n;
    int cyc;
    int w;
    int exp_w;
    int last_w;
    logic g0, g1;
    logic pend_valid, pend_port, pend_chk;
    logic [31:0] pend_data;

    res = 1'b1;
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    #2;
    chk_all_zero("reset");
    tick();
    res = 1'b0;

    // Write then read back through port 0
    drive(0, 1, 1, 6'd5, 32'hDEADBEEF);
    tick();
    chk("wr_p0_gnt",    bus.p0_gnt,    1);
    chk("wr_p1_gnt",    bus.p1_gnt,    0);
    chk("wr_mem_wr",    bus.mem_wr,    1);
    chk("wr_mem_rd",    bus.mem_rd,    0);
    chk("wr_mem_addr",  bus.mem_addr,  5);
    chk("wr_mem_wdata", bus.mem_wdata, 32'hDEADBEEF);
    bus.p0_req = 1'b0;
    tick();
    chk("wr_done_gnt", bus.p0_gnt, 0);
    chk("wr_done_wr",  bus.mem_wr, 0);
    drive(0, 1, 0, 6'd5, 32'h0);
    tick();
    chk("rd_p0_gnt",  bus.p0_gnt, 1);
    chk("rd_mem_rd",  bus.mem_rd, 1);
    chk("rd_mem_wr",  bus.mem_wr, 0);
    bus.p0_req = 1'b0;
    tick();
    chk("rd_p0_rvalid", bus.p0_rvalid, 1);
    chk("rd_p0_rdata",  bus.p0_rdata,  32'hDEADBEEF);
    chk("rd_p1_rvalid", bus.p1_rvalid, 0);
    chk("rd_p0_gnt_resp", bus.p0_gnt, 0);
    tick();
    chk("rd_rvalid_drop", bus.p0_rvalid, 0);

    // Both ports requesting reads continuously from reset
    res = 1'b1;
    tick();
    res = 1'b0;
    drive(0, 1, 0, 6'd1, 0);
    drive(1, 1, 0, 6'd2, 0);
    for (int i = 0; i < 12; i++) begin
      int exp_port;
      tick();
      exp_port = RR ? (i / 3) % 2 : 0;
      chk($sformatf("cont_p0_gnt_%0d", i), bus.p0_gnt, (i % 3 == 0) && (exp_port == 0));
      chk($sformatf("cont_p1_gnt_%0d", i), bus.p1_gnt, (i % 3 == 0) && (exp_port == 1));
    end
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    tick();

    // Port 1 write arriving while port 0 read is in RESP
    drive(0, 1, 0, 6'd5, 0);
    tick();
    chk("late_p0_gnt", bus.p0_gnt, 1);
    bus.p0_req = 1'b0;
    tick();
    chk("late_p0_rvalid", bus.p0_rvalid, 1);
    chk("late_p0_rdata",  bus.p0_rdata,  32'hDEADBEEF);
    drive(1, 1, 1, 6'd63, 32'h12345678);
    tick();
    chk("late_p1_gnt_idle", bus.p1_gnt, 0);
    chk("late_wr_idle",     bus.mem_wr, 0);
    tick();
    chk("late_p1_gnt",      bus.p1_gnt,    1);
    chk("late_mem_wr",      bus.mem_wr,    1);
    chk("late_mem_addr",    bus.mem_addr,  63);
    chk("late_mem_wdata",   bus.mem_wdata, 32'h12345678);
    bus.p1_req = 1'b0;
    tick();

    // Reset pulse during ISSUE of a port 0 read
    drive(0, 1, 0, 6'd63, 0);
    tick();
    chk("abort_p0_gnt", bus.p0_gnt, 1);
    chk("abort_mem_rd", bus.mem_rd, 1);
    bus.p0_req = 1'b0;
    #2;
    res = 1'b1;
    #1;
    chk_all_zero("abort");
    tick();
    chk("abort_held_rd", bus.mem_rd, 0);
    res = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("abort_no_rvalid_%0d", i), bus.p0_rvalid, 0);
    end
    drive(0, 1, 1, 6'd10, 32'hAAAA0001);
    drive(1, 1, 1, 6'd11, 32'hBBBB0002);
    tick();
    chk("post_p0_gnt", bus.p0_gnt, 1);
    chk("post_p1_gnt", bus.p1_gnt, 0);
    bus.p0_req = 1'b0;
    tick();
    tick();
    chk("post_p1_gnt2", bus.p1_gnt, 1);
    bus.p1_req = 1'b0;
    tick();

    // Random traffic against a transaction-level shadow memory
    res = 1'b1;
    tick();
    res = 1'b0;
    for (int a = 0; a < 64; a++) shadow_ok[a] = 1'b0;
    for (int p = 0; p < 2; p++) begin
      r_req[p] = 0; r_we[p] = 0; r_addr[p] = 0; r_wdata[p] = 0; r_age[p] = 0; snap[p] = 0;
    end
    last_w = 1;
    pend_valid = 0; pend_port = 0; pend_chk = 0; pend_data = 0;
    n = 0;
    cyc = 0;
    while (n < 1000 && cyc < 20000) begin
      tick();
      cyc++;
      g0 = bus.p0_gnt;
      g1 = bus.p1_gnt;
      chk("rnd_gnt_excl", g0 & g1, 0);
      chk("rnd_strobe_excl", bus.mem_wr & bus.mem_rd, 0);
      if (pend_valid) begin
        chk("rnd_p0_rvalid", bus.p0_rvalid, pend_port == 1'b0);
        chk("rnd_p1_rvalid", bus.p1_rvalid, pend_port == 1'b1);
        if (pend_chk)
          chk("rnd_rdata", pend_port ? bus.p1_rdata : bus.p0_rdata, pend_data);
        pend_valid = 0;
      end else begin
        chk("rnd_no_rvalid", bus.p0_rvalid | bus.p1_rvalid, 0);
      end
      if (g0 | g1) begin
        w = g1 ? 1 : 0;
        if (snap[0] && snap[1]) exp_w = RR ? 1 - last_w : 0;
        else                    exp_w = snap[1] ? 1 : 0;
        chk("rnd_winner",   w, exp_w);
        chk("rnd_mem_wr",   bus.mem_wr,   r_we[w]);
        chk("rnd_mem_addr", bus.mem_addr, r_addr[w]);
        if (r_we[w]) begin
          chk("rnd_mem_wdata", bus.mem_wdata, r_wdata[w]);
          shadow[r_addr[w]]    = r_wdata[w];
          shadow_ok[r_addr[w]] = 1'b1;
        end else begin
          pend_valid = 1;
          pend_port  = (w == 1);
          pend_chk   = shadow_ok[r_addr[w]];
          pend_data  = shadow[r_addr[w]];
        end
        r_req[w] = 0;
        last_w = w;
        n++;
      end
      for (int p = 0; p < 2; p++) begin
        if (r_req[p]) begin
          r_age[p]++;
          chk("rnd_starve", r_age[p] > 200, 0);
        end else if ($urandom_range(0, 2) != 0) begin
          r_req[p]   = 1'b1;
          r_we[p]    = 1'($urandom_range(0, 1));
          r_addr[p]  = 6'($urandom_range(0, 7));
          r_wdata[p] = $urandom;
          r_age[p]   = 0;
        end
        drive(p, r_req[p], r_we[p], r_addr[p], r_wdata[p]);
        snap[p] = r_req[p];
      end
    end
    chk("rnd_completed", n >= 1000, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
